// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key sequencer.
// Set-2 prefix bytes, prefix FSM encoding and the key event bundle.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_E0   = 2'd1;
   localparam logic [1:0] ST_F0   = 2'd2;
   localparam logic [1:0] ST_E0F0 = 2'd3;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
      logic [7:0] ascii;
   } key_evt_t;

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Byte stream in from the PS/2 receiver and key events out.
// slave is the sequencer side, master is the producer/consumer side.
interface ps2_key_sequencer_if;
   import ps2_pkg::*;

   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       evt_rep;
   logic [7:0] evt_ascii;

   modport master (
      output rx_valid, rx_data, rx_err, evt_ready,
      input  evt_valid, evt_code, evt_ext, evt_brk, evt_rep, evt_ascii
   );

   modport slave (
      input  rx_valid, rx_data, rx_err, evt_ready,
      output evt_valid, evt_code, evt_ext, evt_brk, evt_rep, evt_ascii
   );

endinterface

// File: rtl/ps2_scancode_ascii.sv
// Combinational set-2 scan code to ASCII map (non-extended codes).
// Unmapped codes return 8'h00.
module ps2_scancode_ascii
   import ps2_pkg::*;
(
   input  logic [7:0] code,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = 8'h00;
      case (code)
         8'h1C: ascii = 8'h61;
         8'h32: ascii = 8'h62;
         8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;
         8'h24: ascii = 8'h65;
         8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;
         8'h33: ascii = 8'h68;
         8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;
         8'h42: ascii = 8'h6B;
         8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;
         8'h31: ascii = 8'h6E;
         8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;
         8'h15: ascii = 8'h71;
         8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;
         8'h2C: ascii = 8'h74;
         8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;
         8'h1D: ascii = 8'h77;
         8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;
         8'h1A: ascii = 8'h7A;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h45: ascii = 8'h30;
         8'h29: ascii = 8'h20;
         8'h5A: ascii = 8'h0D;
         8'h66: ascii = 8'h08;
         default: ascii = 8'h00;
      endcase
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 key sequencer: byte FIFO, E0/F0 prefix FSM,
// key event port, held-key/typematic tracking and press counter.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             resetn,
   ps2_key_sequencer_if.slave bus,
   output logic             key_held,
   output logic [7:0]       held_code,
   output logic [CNT_W-1:0] press_count,
   output logic             overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic       fifo_full;
   logic       slot_free;
   logic       pop;
   logic       push;
   logic [7:0] pop_byte;
   logic       b_ext;
   logic       b_brk;
   logic       load;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       cur_ext;
   logic       cur_brk;

   logic       held_ext;
   logic       match;
   logic [7:0] rom_ascii;

   logic       evt_valid;
   key_evt_t   evt_q;

   assign fifo_full = count == (AW+1)'(FIFO_DEPTH);
   assign slot_free = !evt_valid || bus.evt_ready;
   assign pop       = (count != '0) && slot_free;
   assign push      = bus.rx_valid && (!fifo_full || pop);
   assign pop_byte  = mem[rd_ptr];
   assign b_ext     = pop_byte == PS2_EXT;
   assign b_brk     = pop_byte == PS2_BRK;
   assign load      = pop && !b_ext && !b_brk;

   assign cur_ext = (state == ST_E0) || (state == ST_E0F0);
   assign cur_brk = (state == ST_F0) || (state == ST_E0F0);
   assign match   = key_held && (pop_byte == held_code)
                 && (cur_ext == held_ext);

   ps2_scancode_ascii u_ascii (
      .code  (pop_byte),
      .ascii (rom_ascii)
   );

   // A frame error abandons any partial prefix but keeps queued bytes.
   always_comb begin
      state_nxt = state;
      priority case (1'b1)
         bus.rx_err:   state_nxt = ST_IDLE;
         !pop:         state_nxt = state;
         b_ext:        state_nxt = ST_E0;
         b_brk: begin
            if (state == ST_IDLE)
               state_nxt = ST_F0;
            else if (state == ST_E0)
               state_nxt = ST_E0F0;
         end
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.rx_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         state    <= ST_IDLE;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (bus.rx_valid && !push)
            overflow <= 1'b1;
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         evt_valid <= 1'b0;
         evt_q     <= '0;
      end else if (load) begin
         evt_valid   <= 1'b1;
         evt_q.code  <= pop_byte;
         evt_q.ext   <= cur_ext;
         evt_q.brk   <= cur_brk;
         evt_q.rep   <= !cur_brk && match;
         evt_q.ascii <= cur_ext ? 8'h00 : rom_ascii;
      end else if (bus.evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

   // Held key follows the last new make; only its own break clears it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         key_held    <= 1'b0;
         held_code   <= 8'h00;
         held_ext    <= 1'b0;
         press_count <= '0;
      end else if (load) begin
         if (!cur_brk && !match) begin
            key_held    <= 1'b1;
            held_code   <= pop_byte;
            held_ext    <= cur_ext;
            press_count <= press_count + 1'b1;
         end else if (cur_brk && match) begin
            key_held <= 1'b0;
         end
      end
   end

   assign bus.evt_valid = evt_valid;
   assign bus.evt_code  = evt_q.code;
   assign bus.evt_ext   = evt_q.ext;
   assign bus.evt_brk   = evt_q.brk;
   assign bus.evt_rep   = evt_q.rep;
   assign bus.evt_ascii = evt_q.ascii;

endmodule
